redmule_tile_ctrl: RTL and testbench
====================================

Name: redmule_tile_ctrl

Overview:
- Upstream control stage for one RedMulE tile; drives the tile's tile_enable_i, fetch_enable_i, boot_addr_i, mhartid_i, wu_wfe_i and irq_i inputs.
- Sequences power-up, boot, run, sleep/wake and shutdown from host commands.
- Counts wake-up events and latches interrupt sources.
- Instantiated once per tile in the mesh, between the mesh control plane and the tile.

Parameters:
- STABLE_CYCLES, 16: cycles tile_enable_o must be high before fetch_enable_o rises; also the cool-down cycles after fetch_enable_o falls; must be >= 1.
- EVT_CNT_W, 4: width of the saturating pending-wake-event counter.
- N_IRQ, redmule_mesh_pkg::N_IRQ: interrupt vector width.
- WDOG_CYCLES, 1024: drain timeout (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start command pulse
- stop_i  in  1  stop command pulse
- boot_addr_cfg_i  in  32  boot address, captured on accepted start
- hartid_cfg_i  in  32  hart id, captured on accepted start
- event_i  in  1  wake event pulse
- core_sleep_i  in  1  tile core_sleep_o
- irq_src_i  in  N_IRQ  level interrupt sources
- irq_mask_i  in  N_IRQ  1 = enabled
- irq_clr_i  in  N_IRQ  write-1-to-clear pending bits
- tile_enable_o  out  1  to tile
- fetch_enable_o  out  1  to tile
- boot_addr_o  out  32  to tile
- mhartid_o  out  32  to tile
- wu_wfe_o  out  1  to tile, one-cycle pulse
- irq_o  out  N_IRQ  to tile
- busy_o  out  1  state != IDLE
- state_o  out  3  encoded ctrl_state_e
- err_o  out  1  sticky watchdog error

Behaviour:
- All outputs are registered. Reset value is 0 for every output; state is IDLE, counters are 0 and pending bits are 0.
- rst_i asserted mid-operation returns the block to IDLE on the next edge and drops tile_enable_o and fetch_enable_o immediately.
- States: IDLE=0, PWR_UP=1, RUN=2, SLEEP=3, DRAIN=4, COOL=5.
- IDLE:
  - start_i captures the config inputs into boot_addr_o and mhartid_o.
  - Next cycle: tile_enable_o=1, counter cleared, state goes to PWR_UP.
  - stop_i is ignored in IDLE.
- PWR_UP:
  - The counter increments each cycle.
  - When counter == STABLE_CYCLES-1: fetch_enable_o=1, state goes to RUN.
  - fetch_enable_o therefore rises exactly STABLE_CYCLES cycles after tile_enable_o.
- RUN:
  - core_sleep_i=1 moves to SLEEP.
  - stop_i moves to DRAIN and sets fetch_enable_o=0 on the same edge.
- SLEEP:
  - If evt_cnt > 0: pulse wu_wfe_o for one cycle, decrement evt_cnt, go to RUN.
  - core_sleep_i falling without a pending event also returns to RUN, with no pulse.
  - stop_i takes priority over a wake and moves to DRAIN.
- DRAIN:
  - fetch_enable_o=0.
  - Wait for core_sleep_i=1, then clear the counter and go to COOL.
- COOL:
  - Counter counts STABLE_CYCLES cycles, then tile_enable_o=0 and state goes to IDLE.
  - boot_addr_o and mhartid_o hold their values.
- start_i outside IDLE is ignored. stop_i in PWR_UP is honoured: go straight to COOL with fetch_enable_o never raised.
- evt_cnt behaviour:
  - event_i increments evt_cnt in every state except IDLE; it saturates at 2^EVT_CNT_W-1.
  - If event_i arrives on the same cycle as a decrement, the count is unchanged.
  - Cleared on entry to IDLE.
- Interrupts:
  - pending |= irq_src_i each cycle; pending &= ~irq_clr_i.
  - When source and clear hit the same bit in the same cycle, set wins.
  - irq_o = pending & irq_mask_i, registered, one-cycle latency from pending.
  - pending is cleared in IDLE.

Optional Feature:
- Macro: REDMULE_TILE_CTRL_WDOG_EN.
- Defined:
  - A watchdog counter runs in DRAIN.
  - Reaching WDOG_CYCLES without core_sleep_i forces COOL and sets err_o.
  - err_o is sticky until rst_i or an accepted start_i.
- Undefined: DRAIN waits indefinitely and err_o is tied to 0.

Decomposition:
- Add to redmule_tile_pkg:
  - typedef enum logic [2:0] ctrl_state_e.
  - Default localparams for STABLE_CYCLES, EVT_CNT_W and WDOG_CYCLES.
- One sub-module, redmule_irq_latch (sticky pending, mask, clear, N_IRQ parameter); the FSM and counters stay in the top.

Test Plan:
- Reset, then start_i with boot_addr_cfg_i=32'hCC00_0080 and hartid_cfg_i=3 -> boot_addr_o=CC00_0080, mhartid_o=3, tile_enable_o high at cycle 1, fetch_enable_o high at cycle 17 (STABLE_CYCLES=16), state_o=2.
- In RUN, core_sleep_i=1 then two event_i pulses -> one wu_wfe_o pulse and return to RUN. Re-sleep -> second wu_wfe_o pulse; evt_cnt reaches 0.
- 20 event_i pulses with EVT_CNT_W=4 while sleeping -> count saturates at 15; exactly 15 wake pulses over repeated sleeps.
- stop_i in RUN -> fetch_enable_o drops next edge; after core_sleep_i=1, tile_enable_o drops 16 cycles later; busy_o=0.
- irq_src_i[5] one-cycle pulse with mask bit 5 = 1 -> irq_o[5]=1 until irq_clr_i[5]. Simultaneous source and clear on bit 5 -> bit stays set.
- With WDOG_EN and WDOG_CYCLES=64: stop_i with core_sleep_i held 0 -> COOL after 64 cycles, err_o=1; rst_i mid-COOL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/redmule_tile_pkg.sv
// rtl/redmule_tile_pkg.sv - shared types and default parameters for the RedMulE tile control stage
package redmule_tile_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 16;
    localparam int unsigned EVT_CNT_W_DEF     = 4;
    localparam int unsigned WDOG_CYCLES_DEF   = 1024;
    localparam int unsigned N_IRQ_DEF         = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PWR_UP = 3'd1,
        RUN    = 3'd2,
        SLEEP  = 3'd3,
        DRAIN  = 3'd4,
        COOL   = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/redmule_irq_latch.sv
// rtl/redmule_irq_latch.sv - sticky interrupt pending bits with mask and write-1-to-clear
module redmule_irq_latch
    import redmule_tile_pkg::*;
#(
    parameter int unsigned N_IRQ = N_IRQ_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic [N_IRQ-1:0] i_src,
    input  logic [N_IRQ-1:0] i_mask,
    input  logic [N_IRQ-1:0] i_clr,
    output logic [N_IRQ-1:0] o_irq
);

    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_irq;

    // Pending bits: clear first, then OR in sources so a same-cycle set wins.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~i_clr) | i_src;
        end
    end

    // Masked view registered one cycle behind the pending bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq <= '0;
        end else begin
            r_irq <= r_pending & i_mask;
        end
    end

    assign o_irq = r_irq;

endmodule

// File: rtl/redmule_tile_ctrl.sv
// rtl/redmule_tile_ctrl.sv - tile power/boot/sleep sequencer; optional drain watchdog via REDMULE_TILE_CTRL_WDOG_EN
module redmule_tile_ctrl
    import redmule_tile_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned EVT_CNT_W     = EVT_CNT_W_DEF,
    parameter int unsigned N_IRQ         = N_IRQ_DEF,
    parameter int unsigned WDOG_CYCLES   = WDOG_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [31:0]      boot_addr_cfg_i,
    input  logic [31:0]      hartid_cfg_i,
    input  logic             event_i,
    input  logic             core_sleep_i,
    input  logic [N_IRQ-1:0] irq_src_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic [N_IRQ-1:0] irq_clr_i,
    output logic             tile_enable_o,
    output logic             fetch_enable_o,
    output logic [31:0]      boot_addr_o,
    output logic [31:0]      mhartid_o,
    output logic             wu_wfe_o,
    output logic [N_IRQ-1:0] irq_o,
    output logic             busy_o,
    output logic [2:0]       state_o,
    output logic             err_o
);

    // One counter serves power-up, cool-down and the drain watchdog.
    localparam int unsigned CNT_MAX = (STABLE_CYCLES > WDOG_CYCLES) ? STABLE_CYCLES : WDOG_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef REDMULE_TILE_CTRL_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
`endif

    ctrl_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [EVT_CNT_W-1:0] r_evt, w_evt_nxt;
    logic                 r_tile_en, w_tile_en_nxt;
    logic                 r_fetch_en, w_fetch_en_nxt;
    logic                 r_wfe, w_wfe_nxt;
    logic                 r_busy;
    logic                 r_err, w_err_nxt;
    logic [31:0]          r_boot_addr, r_hartid;
    logic                 w_capture;
    logic                 w_dec;

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tile_en_nxt  = r_tile_en;
        w_fetch_en_nxt = r_fetch_en;
        w_wfe_nxt      = 1'b0;
        w_err_nxt      = r_err;
        w_capture      = 1'b0;
        w_dec          = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_capture     = 1'b1;
                    w_tile_en_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_err_nxt     = 1'b0;
                    w_state_nxt   = PWR_UP;
                end
            end
            PWR_UP: begin
                if (stop_i) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = COOL;
                end else if (r_cnt == STABLE_LAST) begin
                    w_fetch_en_nxt = 1'b1;
                    w_state_nxt    = RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (stop_i) begin
                    w_fetch_en_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = DRAIN;
                end else if (core_sleep_i) begin
                    w_state_nxt = SLEEP;
                end
            end
            SLEEP: begin
                if (stop_i) begin
                    w_fetch_en_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = DRAIN;
                end else if (r_evt != '0) begin
                    w_wfe_nxt   = 1'b1;
                    w_dec       = 1'b1;
                    w_state_nxt = RUN;
                end else if (!core_sleep_i) begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                w_fetch_en_nxt = 1'b0;
                if (core_sleep_i) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = COOL;
                end
`ifdef REDMULE_TILE_CTRL_WDOG_EN
                else if (r_cnt == WDOG_LAST) begin
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = COOL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            COOL: begin
                if (r_cnt == STABLE_LAST) begin
                    w_tile_en_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_tile_en_nxt  = 1'b0;
                w_fetch_en_nxt = 1'b0;
                w_state_nxt    = IDLE;
            end
        endcase
    end

    // Pending wake events: saturating, a coincident event and wake cancel out.
    always_comb begin
        w_evt_nxt = r_evt;
        if (r_state == IDLE || w_state_nxt == IDLE) begin
            w_evt_nxt = '0;
        end else if (event_i && !w_dec) begin
            if (!(&r_evt)) begin
                w_evt_nxt = r_evt + EVT_CNT_W'(1);
            end
        end else if (!event_i && w_dec) begin
            w_evt_nxt = r_evt - EVT_CNT_W'(1);
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_evt       <= '0;
            r_tile_en   <= 1'b0;
            r_fetch_en  <= 1'b0;
            r_wfe       <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_boot_addr <= '0;
            r_hartid    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_evt      <= w_evt_nxt;
            r_tile_en  <= w_tile_en_nxt;
            r_fetch_en <= w_fetch_en_nxt;
            r_wfe      <= w_wfe_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_err      <= w_err_nxt;
            if (w_capture) begin
                r_boot_addr <= boot_addr_cfg_i;
                r_hartid    <= hartid_cfg_i;
            end
        end
    end

    redmule_irq_latch #(
        .N_IRQ (N_IRQ)
    ) u_irq_latch (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (r_state == IDLE),
        .i_src   (irq_src_i),
        .i_mask  (irq_mask_i),
        .i_clr   (irq_clr_i),
        .o_irq   (irq_o)
    );

    assign tile_enable_o  = r_tile_en;
    assign fetch_enable_o = r_fetch_en;
    assign boot_addr_o    = r_boot_addr;
    assign mhartid_o      = r_hartid;
    assign wu_wfe_o       = r_wfe;
    assign busy_o         = r_busy;
    assign state_o        = r_state;
    assign err_o          = r_err;

endmodule

// File: tb/tb_redmule_tile_ctrl.sv
// tb/tb_redmule_tile_ctrl.sv - self-checking bench for redmule_tile_ctrl (watchdog test with REDMULE_TILE_CTRL_WDOG_EN)
module tb_redmule_tile_ctrl;

    localparam int unsigned STABLE = 16;
    localparam int unsigned EVTW   = 4;
    localparam int unsigned NIRQ   = 8;
    localparam int unsigned WDOG   = 64;
    localparam int          EVT_MAX = (1 << EVTW) - 1;
`ifdef REDMULE_TILE_CTRL_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic            clk, rst, start, stop, event_p, core_sleep;
    logic [31:0]     boot_cfg, hart_cfg;
    logic [NIRQ-1:0] irq_src, irq_mask, irq_clr;
    logic            tile_enable_o, fetch_enable_o, wu_wfe_o, busy_o, err_o;
    logic [31:0]     boot_addr_o, mhartid_o;
    logic [NIRQ-1:0] irq_o;
    logic [2:0]      state_o;

    int checks = 0;
    int errors = 0;

    redmule_tile_ctrl #(
        .STABLE_CYCLES (STABLE),
        .EVT_CNT_W     (EVTW),
        .N_IRQ         (NIRQ),
        .WDOG_CYCLES   (WDOG)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .stop_i          (stop),
        .boot_addr_cfg_i (boot_cfg),
        .hartid_cfg_i    (hart_cfg),
        .event_i         (event_p),
        .core_sleep_i    (core_sleep),
        .irq_src_i       (irq_src),
        .irq_mask_i      (irq_mask),
        .irq_clr_i       (irq_clr),
        .tile_enable_o   (tile_enable_o),
        .fetch_enable_o  (fetch_enable_o),
        .boot_addr_o     (boot_addr_o),
        .mhartid_o       (mhartid_o),
        .wu_wfe_o        (wu_wfe_o),
        .irq_o           (irq_o),
        .busy_o          (busy_o),
        .state_o         (state_o),
        .err_o           (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: phase number, cycles spent in the phase, pending events and IRQ bits.
    int              m_phase, m_age, m_evt;
    bit              m_on;
    logic [NIRQ-1:0] m_pend;
    logic            e_ten, e_fen, e_wfe, e_busy, e_err;
    logic [31:0]     e_boot, e_hart;
    logic [NIRQ-1:0] e_irq;

    always @(posedge clk) begin
        int nxt, dec, tmp;
        if (rst) begin
            m_on = 1'b1; m_phase = 0; m_age = 0; m_evt = 0; m_pend = '0;
            e_ten = 0; e_fen = 0; e_wfe = 0; e_busy = 0; e_err = 0;
            e_boot = '0; e_hart = '0; e_irq = '0;
        end else if (m_on) begin
            nxt = m_phase; dec = 0; e_wfe = 0;
            m_age = m_age + 1;
            case (m_phase)
                0: if (start) begin
                       e_boot = boot_cfg; e_hart = hart_cfg; e_ten = 1; e_err = 0; nxt = 1;
                   end
                1: if (stop) nxt = 5;
                   else if (m_age == STABLE) begin e_fen = 1; nxt = 2; end
                2: if (stop) begin e_fen = 0; nxt = 4; end
                   else if (core_sleep) nxt = 3;
                3: if (stop) begin e_fen = 0; nxt = 4; end
                   else if (m_evt > 0) begin e_wfe = 1; dec = 1; nxt = 2; end
                   else if (!core_sleep) nxt = 2;
                4: if (core_sleep) nxt = 5;
                   else if (WDOG_EN && m_age == WDOG) begin e_err = 1; nxt = 5; end
                5: if (m_age == STABLE) begin e_ten = 0; nxt = 0; end
                default: nxt = 0;
            endcase
            if (m_phase == 0 || nxt == 0) m_evt = 0;
            else begin
                tmp = m_evt + (event_p ? 1 : 0) - dec;
                m_evt = (tmp > EVT_MAX) ? EVT_MAX : tmp;
            end
            e_irq  = m_pend & irq_mask;
            m_pend = (m_phase == 0) ? '0 : ((m_pend & ~irq_clr) | irq_src);
            if (nxt != m_phase) m_age = 0;
            m_phase = nxt;
            e_busy  = (m_phase != 0);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (m_on) begin
            chk("tile_enable_o", 32'(tile_enable_o), 32'(e_ten));
            chk("fetch_enable_o", 32'(fetch_enable_o), 32'(e_fen));
            chk("boot_addr_o", boot_addr_o, e_boot);
            chk("mhartid_o", mhartid_o, e_hart);
            chk("wu_wfe_o", 32'(wu_wfe_o), 32'(e_wfe));
            chk("irq_o", 32'(irq_o), 32'(e_irq));
            chk("busy_o", 32'(busy_o), 32'(e_busy));
            chk("state_o", 32'(state_o), 32'(m_phase));
            chk("err_o", 32'(err_o), 32'(e_err));
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic wait_state(input logic [2:0] s, input int max_cyc);
        bit found = 0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(posedge clk); #1;
            if (state_o == s) found = 1;
        end
        chk("wait_state", 32'(found), 32'd1);
    endtask

    task automatic pulse_start(input logic [31:0] ba, input logic [31:0] hid);
        @(negedge clk); start = 1; boot_cfg = ba; hart_cfg = hid;
        @(negedge clk); start = 0;
    endtask

    task automatic sleep_cycle(output bit woke);
        woke = 0;
        @(negedge clk); core_sleep = 1;
        for (int i = 0; i < 6 && !woke; i++) begin
            @(posedge clk); #1;
            if (wu_wfe_o) woke = 1;
        end
        @(negedge clk); core_sleep = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit woke;
        int n, wakes;
        bit seen;
        rst = 1; start = 0; stop = 0; event_p = 0; core_sleep = 0;
        boot_cfg = '0; hart_cfg = '0; irq_src = '0; irq_clr = '0; irq_mask = 8'h20;
        repeat (2) @(posedge clk); #1;
        chk("rst tile_en", 32'(tile_enable_o), 0);
        chk("rst state", 32'(state_o), 0);
        chk("rst boot", boot_addr_o, 0);
        @(negedge clk); rst = 0;

        // Boot: tile_enable one edge after start, fetch_enable 16 edges later.
        @(negedge clk); start = 1; boot_cfg = 32'hCC00_0080; hart_cfg = 32'd3;
        @(posedge clk); #1;
        chk("boot tile_en", 32'(tile_enable_o), 1);
        chk("boot addr", boot_addr_o, 32'hCC00_0080);
        chk("boot hartid", mhartid_o, 3);
        @(negedge clk); start = 0;
        seen = 0;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            if (fetch_enable_o) seen = 1;
        end
        chk("fetch early", 32'(seen), 0);
        @(posedge clk); #1;
        chk("fetch at 16", 32'(fetch_enable_o), 1);
        chk("run state", 32'(state_o), 2);

        // start outside IDLE leaves the captured config alone.
        pulse_start(32'hDEAD_0000, 32'd7);
        @(posedge clk); #1;
        chk("start ignored addr", boot_addr_o, 32'hCC00_0080);
        chk("start ignored hart", mhartid_o, 3);

        // Interrupt latch, mask, clear and set-wins.
        @(negedge clk); irq_src = 8'h20;
        @(negedge clk); irq_src = 8'h00;
        repeat (3) @(posedge clk); #1;
        chk("irq5 latched", 32'(irq_o), 32'h20);
        @(negedge clk); irq_clr = 8'h20;
        @(negedge clk); irq_clr = 8'h00;
        repeat (2) @(posedge clk); #1;
        chk("irq5 cleared", 32'(irq_o), 0);
        @(negedge clk); irq_src = 8'h20; irq_clr = 8'h20;
        @(negedge clk); irq_src = 8'h00; irq_clr = 8'h00;
        repeat (2) @(posedge clk); #1;
        chk("irq5 set wins", 32'(irq_o), 32'h20);
        @(negedge clk); irq_src = 8'h08;
        @(negedge clk); irq_src = 8'h00;
        repeat (2) @(posedge clk); #1;
        chk("irq3 masked", 32'(irq_o), 32'h20);
        @(negedge clk); irq_mask = 8'h28;
        repeat (2) @(posedge clk); #1;
        chk("irq3 unmasked", 32'(irq_o), 32'h28);
        @(negedge clk); irq_clr = 8'h28;
        @(negedge clk); irq_clr = 8'h00; irq_mask = 8'h20;

        // Sleep with two back-to-back events: one wake now, one on re-sleep.
        @(negedge clk); core_sleep = 1;
        @(posedge clk); #1;
        chk("sleep state", 32'(state_o), 3);
        @(negedge clk); event_p = 1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("wake pulse 1", 32'(wu_wfe_o), 1);
        chk("wake run", 32'(state_o), 2);
        @(negedge clk); event_p = 0; core_sleep = 0;
        @(posedge clk); #1;
        chk("wake pulse width", 32'(wu_wfe_o), 0);
        sleep_cycle(woke);
        chk("wake pulse 2", 32'(woke), 1);
        sleep_cycle(woke);
        chk("no pending wake", 32'(woke), 0);

        // 20 events saturate at 15: exactly 15 wakes.
        @(negedge clk); event_p = 1;
        repeat (20) @(negedge clk);
        event_p = 0;
        wakes = 0;
        for (int i = 0; i < 17; i++) begin
            sleep_cycle(woke);
            if (woke) wakes++;
        end
        chk("saturated wakes", 32'(wakes), 15);

        // Stop in RUN: fetch drops at once, tile drops 16 edges after core sleeps.
        wait_state(3'd2, 20);
        @(negedge clk); stop = 1;
        @(posedge clk); #1;
        chk("stop fetch", 32'(fetch_enable_o), 0);
        chk("drain state", 32'(state_o), 4);
        @(negedge clk); stop = 0;
        repeat (10) @(posedge clk); #1;
        chk("drain waits", 32'(state_o), 4);
        @(negedge clk); core_sleep = 1;
        @(posedge clk); #1;
        chk("cool state", 32'(state_o), 5);
        seen = 0;
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            if (!tile_enable_o) seen = 1;
        end
        chk("cool tile held", 32'(seen), 0);
        @(posedge clk); #1;
        chk("cool tile off", 32'(tile_enable_o), 0);
        chk("cool busy", 32'(busy_o), 0);
        @(negedge clk); core_sleep = 0;

        // Stop during power-up: straight to COOL, fetch never rises.
        pulse_start(32'h0000_1000, 32'd9);
        @(negedge clk); stop = 1;
        @(negedge clk); stop = 0;
        n = 0; seen = 0;
        for (int i = 0; i < 40 && state_o != 3'd0; i++) begin
            @(posedge clk); #1;
            n++;
            if (fetch_enable_o) seen = 1;
        end
        chk("pwrup stop fetch", 32'(seen), 0);
        chk("pwrup stop cycles", 32'(n), 16);
        chk("pwrup stop addr", boot_addr_o, 32'h0000_1000);

        // Reset mid-RUN clears every output on the next edge.
        pulse_start(32'h0000_2000, 32'd4);
        wait_state(3'd2, 40);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        chk("midrst tile_en", 32'(tile_enable_o), 0);
        chk("midrst fetch", 32'(fetch_enable_o), 0);
        chk("midrst state", 32'(state_o), 0);
        chk("midrst hart", mhartid_o, 0);
        @(negedge clk); rst = 0;

`ifdef REDMULE_TILE_CTRL_WDOG_EN
        // Watchdog: DRAIN with no core sleep forces COOL after 64 cycles.
        pulse_start(32'h0000_3000, 32'd5);
        wait_state(3'd2, 40);
        @(negedge clk); stop = 1;
        @(negedge clk); stop = 0;
        n = 0;
        for (int i = 0; i < 200 && state_o != 3'd5; i++) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wdog cycles", 32'(n), 64);
        chk("wdog err", 32'(err_o), 1);
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        chk("wdog rst err", 32'(err_o), 0);
        chk("wdog rst tile", 32'(tile_enable_o), 0);
        chk("wdog rst state", 32'(state_o), 0);
        @(negedge clk); rst = 0;
`endif

        repeat (3) @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
